// File: rtl/uart_ram_programmer.sv
// UART loader: after the magic sequence it holds the system in reset and streams words into RAM.
// Strobe appears one cycle after the 4th byte of each word; the serial input has no backpressure.
module uart_ram_programmer #(
    parameter int                      CLK_FREQ     = 50_000_000,
    parameter int                      BAUD_RATE    = 115200,
    parameter int                      SEQ_LENGTH   = 5,
    parameter logic [8*SEQ_LENGTH-1:0] MAGIC_SEQ    = "CERES",
    parameter int                      BREAK_CYCLES = 1_000_000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        uart_rx_i,
    output logic [31:0] prog_addr_o,
    output logic [31:0] prog_data_o,
    output logic        prog_valid_o,
    output logic        prog_mode_o,
    output logic        system_reset_o
);

    localparam int                DIV        = CLK_FREQ / BAUD_RATE;
    localparam int                CNT_W      = $clog2(DIV + 1);
    localparam logic [CNT_W-1:0]  DIV_LAST   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST  = CNT_W'(DIV / 2 - 1);
    localparam int                IDX_W      = $clog2(SEQ_LENGTH + 1);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(SEQ_LENGTH - 1);
    localparam logic [31:0]       BREAK_LAST = 32'(BREAK_CYCLES - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {SYNC, COUNT, DATA} state_t;

    logic             rx_meta, rx_sync, rx_prev;
    rx_state_t        rx_state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_shift;
    logic [7:0]       rx_byte;
    logic             rx_byte_vld;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [1:0]       byte_cnt;
    logic [31:0]      word_count;
    logic [31:0]      data_sr;
    logic [31:0]      words_done;
    logic [31:0]      addr;
    logic [31:0]      idle_cnt;
    logic             last_q;
    logic [31:0]      count_full;
    logic [31:0]      word_full;

    assign count_full     = {rx_byte, word_count[31:8]};
    assign word_full      = {rx_byte, data_sr[31:8]};
    assign system_reset_o = prog_mode_o;

    // First magic byte sits in the most significant position (string order).
    function automatic logic [7:0] magic_byte(input logic [IDX_W-1:0] i);
        logic [8*SEQ_LENGTH-1:0] sh;
        sh = MAGIC_SEQ << (8 * i);
        return sh[8*SEQ_LENGTH-1 -: 8];
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta     <= 1'b0;
            rx_sync     <= 1'b0;
            rx_prev     <= 1'b0;
            rx_state    <= RX_IDLE;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            rx_shift    <= '0;
            rx_byte     <= '0;
            rx_byte_vld <= 1'b0;
        end else begin
            rx_meta     <= uart_rx_i;
            rx_sync     <= rx_meta;
            rx_prev     <= rx_sync;
            rx_byte_vld <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state <= RX_START;
                        baud_cnt <= '0;
                    end
                end
                RX_START: begin
                    // Re-check mid start bit so short glitches are rejected.
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (baud_cnt == DIV_LAST) begin
                        baud_cnt <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        bit_idx  <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7)
                            rx_state <= RX_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (baud_cnt == DIV_LAST) begin
                        baud_cnt <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_sync) begin
                            rx_byte     <= rx_shift;
                            rx_byte_vld <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= SYNC;
            idx          <= '0;
            byte_cnt     <= '0;
            word_count   <= '0;
            data_sr      <= '0;
            words_done   <= '0;
            addr         <= '0;
            idle_cnt     <= '0;
            last_q       <= 1'b0;
            prog_addr_o  <= '0;
            prog_data_o  <= '0;
            prog_valid_o <= 1'b0;
            prog_mode_o  <= 1'b0;
        end else begin
            prog_valid_o <= 1'b0;
            // Mode drops one cycle after the final strobe of a session.
            if (last_q) begin
                last_q      <= 1'b0;
                prog_mode_o <= 1'b0;
            end
            case (state)
                SYNC: begin
                    if (rx_byte_vld) begin
                        if (rx_byte == magic_byte(idx)) begin
                            if (idx == IDX_LAST) begin
                                state       <= COUNT;
                                idx         <= '0;
                                byte_cnt    <= '0;
                                words_done  <= '0;
                                addr        <= '0;
                                idle_cnt    <= '0;
                                prog_mode_o <= 1'b1;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end else begin
                            idx <= (rx_byte == magic_byte('0)) ? IDX_W'(1) : '0;
                        end
                    end
                end
                COUNT: begin
                    if (rx_byte_vld) begin
                        idle_cnt   <= '0;
                        word_count <= count_full;
                        byte_cnt   <= byte_cnt + 1'b1;
                        if (byte_cnt == 2'd3) begin
                            if (count_full == 32'd0) begin
                                state       <= SYNC;
                                prog_mode_o <= 1'b0;
                            end else begin
                                state <= DATA;
                            end
                        end
                    end else if (idle_cnt == BREAK_LAST) begin
                        state       <= SYNC;
                        prog_mode_o <= 1'b0;
                    end else begin
                        idle_cnt <= idle_cnt + 32'd1;
                    end
                end
                DATA: begin
                    if (rx_byte_vld) begin
                        idle_cnt <= '0;
                        data_sr  <= word_full;
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == 2'd3) begin
                            prog_data_o  <= word_full;
                            prog_addr_o  <= addr;
                            prog_valid_o <= 1'b1;
                            addr         <= addr + 32'd1;
                            words_done   <= words_done + 32'd1;
                            if (words_done + 32'd1 == word_count) begin
                                state  <= SYNC;
                                last_q <= 1'b1;
                            end
                        end
                    end else if (idle_cnt == BREAK_LAST) begin
                        state       <= SYNC;
                        prog_mode_o <= 1'b0;
                    end else begin
                        idle_cnt <= idle_cnt + 32'd1;
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_ram_programmer.sv
// Directed bench for uart_ram_programmer: serial sessions, resync, timeout, framing and reset cases.
module tb_uart_ram_programmer;

    localparam int DIV   = 10;
    localparam int BREAK = 2000;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        uart_rx_i = 1'b1;
    logic [31:0] prog_addr_o;
    logic [31:0] prog_data_o;
    logic        prog_valid_o;
    logic        prog_mode_o;
    logic        system_reset_o;

    int checks = 0;
    int failures = 0;
    int base;

    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    logic        q_mode_at[$];
    logic        q_mode_after[$];
    logic        pend = 1'b0;

    uart_ram_programmer #(
        .CLK_FREQ    (1_000_000),
        .BAUD_RATE   (100_000),
        .SEQ_LENGTH  (5),
        .MAGIC_SEQ   ("CERES"),
        .BREAK_CYCLES(BREAK)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .uart_rx_i     (uart_rx_i),
        .prog_addr_o   (prog_addr_o),
        .prog_data_o   (prog_data_o),
        .prog_valid_o  (prog_valid_o),
        .prog_mode_o   (prog_mode_o),
        .system_reset_o(system_reset_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (pend) q_mode_after.push_back(prog_mode_o);
        pend = prog_valid_o;
        if (prog_valid_o) begin
            q_addr.push_back(prog_addr_o);
            q_data.push_back(prog_data_o);
            q_mode_at.push_back(prog_mode_o);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_strobe(input string tag, input int k, input logic [31:0] exp_addr,
                                input logic [31:0] exp_data, input logic exp_after);
        if (k < q_addr.size()) begin
            check({tag, "_addr"}, q_addr[k], exp_addr);
            check({tag, "_data"}, q_data[k], exp_data);
            check({tag, "_mode_at"}, 32'(q_mode_at[k]), 32'd1);
            if (k < q_mode_after.size())
                check({tag, "_mode_after"}, 32'(q_mode_after[k]), 32'(exp_after));
        end else begin
            check({tag, "_missing"}, 32'(q_addr.size()), 32'(k + 1));
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        uart_rx_i = 1'b0;
        repeat (DIV) @(posedge clk_i);
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = b[i];
            repeat (DIV) @(posedge clk_i);
        end
        uart_rx_i = stop_bit;
        repeat (DIV) @(posedge clk_i);
        uart_rx_i = 1'b1;
        repeat (DIV) @(posedge clk_i);
        #1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_mode"}, 32'(prog_mode_o), 32'd0);
        check({tag, "_sysrst"}, 32'(system_reset_o), 32'd0);
        check({tag, "_valid"}, 32'(prog_valid_o), 32'd0);
        check({tag, "_addr"}, prog_addr_o, 32'd0);
        check({tag, "_data"}, prog_data_o, 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (5) @(posedge clk_i);
        #1;
        check_outputs_zero("reset");
        rst_ni = 1'b1;
        repeat (20) @(posedge clk_i);
        #1;

        // 1: basic two-word session
        base = q_addr.size();
        send_str("CERE");
        check("t1_mode_before_S", 32'(prog_mode_o), 32'd0);
        send_byte("S");
        check("t1_mode_rise", 32'(prog_mode_o), 32'd1);
        check("t1_sysrst_rise", 32'(system_reset_o), 32'd1);
        send_word(32'd2);
        send_word(32'h1234_5678);
        send_word(32'hDEAD_BEEF);
        check("t1_nstrobe", 32'(q_addr.size() - base), 32'd2);
        check_strobe("t1_s0", base, 32'd0, 32'h1234_5678, 1'b1);
        check_strobe("t1_s1", base + 1, 32'd1, 32'hDEAD_BEEF, 1'b0);
        check("t1_mode_end", 32'(prog_mode_o), 32'd0);

        // 2: partial restart on mismatch
        base = q_addr.size();
        send_str("CECERES");
        check("t2_mode", 32'(prog_mode_o), 32'd1);
        send_word(32'd1);
        send_word(32'hAABB_CCDD);
        check("t2_nstrobe", 32'(q_addr.size() - base), 32'd1);
        check_strobe("t2_s0", base, 32'd0, 32'hAABB_CCDD, 1'b0);

        // 3: inactivity timeout, then a fresh session
        base = q_addr.size();
        send_str("CERES");
        send_word(32'd3);
        send_word(32'hCAFE_F00D);
        check("t3_mode_mid", 32'(prog_mode_o), 32'd1);
        repeat (BREAK + 10) @(posedge clk_i);
        #1;
        check("t3_mode_timeout", 32'(prog_mode_o), 32'd0);
        check("t3_nstrobe", 32'(q_addr.size() - base), 32'd1);
        check_strobe("t3_s0", base, 32'd0, 32'hCAFE_F00D, 1'b1);
        send_str("CERES");
        check("t3_mode_reenter", 32'(prog_mode_o), 32'd1);
        send_word(32'd1);
        send_word(32'h0102_0304);
        check_strobe("t3_s1", base + 1, 32'd0, 32'h0102_0304, 1'b0);

        // 4: zero word count
        base = q_addr.size();
        send_str("CERES");
        for (int i = 0; i < 3; i++) begin
            send_byte(8'h00);
            check($sformatf("t4_mode_b%0d", i), 32'(prog_mode_o), 32'd1);
        end
        send_byte(8'h00);
        check("t4_mode_end", 32'(prog_mode_o), 32'd0);
        check("t4_nstrobe", 32'(q_addr.size() - base), 32'd0);

        // 5: framing error and start glitch must not disturb the match
        base = q_addr.size();
        send_str("CERE");
        send_byte("S", 1'b0);
        check("t5_mode_framing", 32'(prog_mode_o), 32'd0);
        uart_rx_i = 1'b0;
        repeat (2) @(posedge clk_i);
        uart_rx_i = 1'b1;
        repeat (30) @(posedge clk_i);
        #1;
        check("t5_mode_glitch", 32'(prog_mode_o), 32'd0);
        send_byte("S");
        check("t5_mode_match", 32'(prog_mode_o), 32'd1);
        send_word(32'd0);
        check("t5_mode_end", 32'(prog_mode_o), 32'd0);
        check("t5_nstrobe", 32'(q_addr.size() - base), 32'd0);

        // 6: asynchronous reset in the middle of a data byte
        base = q_addr.size();
        send_str("CERES");
        send_word(32'd3);
        send_word(32'h1122_3344);
        send_word(32'h5566_7788);
        check_strobe("t6_s1", base + 1, 32'd1, 32'h5566_7788, 1'b1);
        send_byte(8'h99);
        uart_rx_i = 1'b0;
        repeat (35) @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        check_outputs_zero("t6_reset");
        uart_rx_i = 1'b1;
        repeat (5) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        repeat (20) @(posedge clk_i);
        #1;
        base = q_addr.size();
        send_str("CERES");
        check("t6_mode_fresh", 32'(prog_mode_o), 32'd1);
        send_word(32'd1);
        send_word(32'h0BAD_F00D);
        check("t6_nstrobe", 32'(q_addr.size() - base), 32'd1);
        check_strobe("t6_s2", base, 32'd0, 32'h0BAD_F00D, 1'b0);
        check("t6_mode_end", 32'(prog_mode_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
